// File: rtl/memory_access_stage.sv
// memory_access_stage: pipeline M stage. Issues loads/stores to data memory over a
// req/ready handshake, stalls upstream while an access is outstanding, and registers
// the write-back bundle. TIMEOUT (0 = off) aborts an access that never gets ready.
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses in IDLE (flagged on MisalignW) instead of issuing them.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module memory_access_stage #(
    parameter int unsigned DW      = `WORD_SIZE,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ValidM,
    input  logic [DW-1:0] ALUResultM,
    input  logic [DW-1:0] WriteDataM,
    input  logic [DW-1:0] PCPlus4M,
    input  logic [4:0]    RdM,
    input  logic          RegWriteM,
    input  logic          MemWriteM,
    input  logic [1:0]    ResultSrcM,
    input  logic [2:0]    Funct3M,
    output logic          StallM,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    output logic [3:0]    dmem_be,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ready,
    output logic          ValidW,
    output logic [DW-1:0] ALUResultW,
    output logic [DW-1:0] ReadDataW,
    output logic [DW-1:0] PCPlus4W,
    output logic [4:0]    RdW,
    output logic          RegWriteW,
    output logic [1:0]    ResultSrcW,
    output logic          BusErrW,
    output logic          MisalignW
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Latched access fields (valid while in ACCESS)
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [4:0]    rd_q, rd_d;
    logic          regwrite_q, regwrite_d;
    logic [1:0]    resultsrc_q, resultsrc_d;
    logic [2:0]    funct3_q, funct3_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic          req_q, req_d;

    // Write-back bundle registers
    logic          valid_w_q, valid_w_d;
    logic [DW-1:0] alu_w_q, alu_w_d;
    logic [DW-1:0] read_w_q, read_w_d;
    logic [DW-1:0] pc_w_q, pc_w_d;
    logic [4:0]    rd_w_q, rd_w_d;
    logic          regwrite_w_q, regwrite_w_d;
    logic [1:0]    resultsrc_w_q, resultsrc_w_d;
    logic          buserr_w_q, buserr_w_d;
    logic          misalign_w_q, misalign_w_d;

    // Decoded M-stage helpers
    logic          memop_c;
    logic          misalign_c;
    logic [3:0]    be_c;
    logic [DW-1:0] wdata_c;

    // Load lane extraction helpers
    logic [7:0]    byte_c;
    logic [15:0]   half_c;
    logic [DW-1:0] load_c;

    // Decode the incoming M bundle: memop, byte enables, replicated store data, alignment
    always_comb begin
        memop_c = ValidM && (MemWriteM || (ResultSrcM == 2'b01));
        be_c    = 4'b1111;
        wdata_c = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ALUResultM[1:0];
                wdata_c = {(DW/8){WriteDataM[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {ALUResultM[1], 1'b0};
                wdata_c = {(DW/16){WriteDataM[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = WriteDataM;
            end
        endcase
`ifdef MEM_MISALIGN_CHECK_EN
        case (Funct3M[1:0])
            2'b01:   misalign_c = ALUResultM[0];
            2'b10:   misalign_c = |ALUResultM[1:0];
            default: misalign_c = 1'b0;
        endcase
`else
        misalign_c = 1'b0;
`endif
    end

    // Select and extend the load lane from returned memory data
    always_comb begin
        case (addr_q[1:0])
            2'b01:   byte_c = dmem_rdata[15:8];
            2'b10:   byte_c = dmem_rdata[23:16];
            2'b11:   byte_c = dmem_rdata[31:24];
            default: byte_c = dmem_rdata[7:0];
        endcase
        half_c = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_c = dmem_rdata;
        case (funct3_q)
            3'b000:  load_c = {{(DW-8){byte_c[7]}}, byte_c};
            3'b001:  load_c = {{(DW-16){half_c[15]}}, half_c};
            3'b100:  load_c = {{(DW-8){1'b0}}, byte_c};
            3'b101:  load_c = {{(DW-16){1'b0}}, half_c};
            default: load_c = dmem_rdata;
        endcase
    end

    // Next-state and next-output logic for the IDLE/ACCESS controller
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        pc_d          = pc_q;
        rd_d          = rd_q;
        regwrite_d    = regwrite_q;
        resultsrc_d   = resultsrc_q;
        funct3_d      = funct3_q;
        we_d          = we_q;
        be_d          = be_q;
        valid_w_d     = 1'b0;
        regwrite_w_d  = 1'b0;
        buserr_w_d    = 1'b0;
        misalign_w_d  = 1'b0;
        alu_w_d       = alu_w_q;
        read_w_d      = read_w_q;
        pc_w_d        = pc_w_q;
        rd_w_d        = rd_w_q;
        resultsrc_w_d = resultsrc_w_q;

        case (state_q)
            S_IDLE: begin
                if (memop_c) begin
                    if (misalign_c) begin
                        valid_w_d     = 1'b1;
                        misalign_w_d  = 1'b1;
                        alu_w_d       = ALUResultM;
                        read_w_d      = '0;
                        pc_w_d        = PCPlus4M;
                        rd_w_d        = RdM;
                        resultsrc_w_d = ResultSrcM;
                    end else begin
                        addr_d      = ALUResultM;
                        wdata_d     = wdata_c;
                        pc_d        = PCPlus4M;
                        rd_d        = RdM;
                        regwrite_d  = RegWriteM;
                        resultsrc_d = ResultSrcM;
                        funct3_d    = Funct3M;
                        we_d        = MemWriteM;
                        be_d        = be_c;
                        cnt_d       = '0;
                        state_d     = S_ACCESS;
                    end
                end else if (ValidM) begin
                    valid_w_d     = 1'b1;
                    regwrite_w_d  = RegWriteM;
                    alu_w_d       = ALUResultM;
                    read_w_d      = '0;
                    pc_w_d        = PCPlus4M;
                    rd_w_d        = RdM;
                    resultsrc_w_d = ResultSrcM;
                end
            end
            S_ACCESS: begin
                if (dmem_ready) begin
                    valid_w_d     = 1'b1;
                    regwrite_w_d  = regwrite_q;
                    alu_w_d       = addr_q;
                    read_w_d      = we_q ? '0 : load_c;
                    pc_w_d        = pc_q;
                    rd_w_d        = rd_q;
                    resultsrc_w_d = resultsrc_q;
                    we_d          = 1'b0;
                    be_d          = 4'b0000;
                    state_d       = S_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    // Hung access: retire as a bus error that never writes the register file
                    valid_w_d     = 1'b1;
                    buserr_w_d    = 1'b1;
                    alu_w_d       = addr_q;
                    read_w_d      = '0;
                    pc_w_d        = pc_q;
                    rd_w_d        = rd_q;
                    resultsrc_w_d = resultsrc_q;
                    we_d          = 1'b0;
                    be_d          = 4'b0000;
                    state_d       = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_d = (state_d == S_ACCESS);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched access fields and write-back bundle registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            pc_q          <= '0;
            rd_q          <= '0;
            regwrite_q    <= 1'b0;
            resultsrc_q   <= '0;
            funct3_q      <= '0;
            we_q          <= 1'b0;
            be_q          <= '0;
            req_q         <= 1'b0;
            valid_w_q     <= 1'b0;
            alu_w_q       <= '0;
            read_w_q      <= '0;
            pc_w_q        <= '0;
            rd_w_q        <= '0;
            regwrite_w_q  <= 1'b0;
            resultsrc_w_q <= '0;
            buserr_w_q    <= 1'b0;
            misalign_w_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            pc_q          <= pc_d;
            rd_q          <= rd_d;
            regwrite_q    <= regwrite_d;
            resultsrc_q   <= resultsrc_d;
            funct3_q      <= funct3_d;
            we_q          <= we_d;
            be_q          <= be_d;
            req_q         <= req_d;
            valid_w_q     <= valid_w_d;
            alu_w_q       <= alu_w_d;
            read_w_q      <= read_w_d;
            pc_w_q        <= pc_w_d;
            rd_w_q        <= rd_w_d;
            regwrite_w_q  <= regwrite_w_d;
            resultsrc_w_q <= resultsrc_w_d;
            buserr_w_q    <= buserr_w_d;
            misalign_w_q  <= misalign_w_d;
        end
    end

    assign StallM     = req_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_be    = be_q;
    assign dmem_addr  = {addr_q[DW-1:2], 2'b00};
    assign dmem_wdata = wdata_q;

    assign ValidW     = valid_w_q;
    assign ALUResultW = alu_w_q;
    assign ReadDataW  = read_w_q;
    assign PCPlus4W   = pc_w_q;
    assign RdW        = rd_w_q;
    assign RegWriteW  = regwrite_w_q;
    assign ResultSrcW = resultsrc_w_q;
    assign BusErrW    = buserr_w_q;
    assign MisalignW  = misalign_w_q;

endmodule
